// File: rtl/opt_pkg.sv
// Shared types and constants for the one-time-pad key sequencer.
package opt_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    RUN       = 2'd2,
    EXHAUSTED = 2'd3
  } opt_state_t;

  localparam int KEY_DEPTH_DEF = 16;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  localparam int PTR_W = ptr_width(KEY_DEPTH_DEF);

endpackage

// File: rtl/opt_key_buf.sv
// Key byte register file: synchronous write, combinational read, synchronous zeroize.
module opt_key_buf
  import opt_pkg::*;
#(
  parameter int DEPTH  = KEY_DEPTH_DEF,
  parameter int DATA_W = 8,
  parameter int AW     = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              zero,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (zero) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/opt_key_sequencer.sv
// One-time-pad sequencer: loads a key, then XORs each data byte with the next unused key byte.
// Optional repeating-key test mode: define OPT_KEY_WRAP_EN.
module opt_key_sequencer
  import opt_pkg::*;
#(
  parameter int KEY_DEPTH = KEY_DEPTH_DEF,
  parameter int DATA_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     cmd_load,
  input  logic                     clear,
  input  logic                     key_valid,
  input  logic [DATA_W-1:0]        key_byte,
  input  logic                     key_last,
  output logic                     key_ready,
  input  logic                     din_valid,
  input  logic [DATA_W-1:0]        din,
  output logic                     din_ready,
  output logic                     dout_valid,
  output logic [DATA_W-1:0]        dout,
  input  logic                     dout_ready,
  output logic                     busy,
  output logic                     exhausted,
  output logic [$clog2(KEY_DEPTH):0] key_count
);

  localparam int PW = ptr_width(KEY_DEPTH);
  localparam logic [PW:0] CNT_LAST = (PW+1)'(KEY_DEPTH - 1);

  opt_state_t state, state_nxt;

  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       cnt, rd_idx, rd_inc;
  logic [DATA_W-1:0] key_rd, dout_p1;
  logic              vld_p1;
  logic              key_acc, din_acc, last_key, last_rd, load_go;
`ifdef OPT_KEY_WRAP_EN
  logic              wrap_p1;
`endif

  assign rd_inc = rd_idx + 1'b1;

  opt_key_buf #(
    .DEPTH  (KEY_DEPTH),
    .DATA_W (DATA_W),
    .AW     (PW)
  ) u_buf (
    .clk   (clk),
    .zero  (!rst_n || clear),
    .we    (key_acc),
    .waddr (wr_ptr),
    .wdata (key_byte),
    .raddr (rd_idx[PW-1:0]),
    .rdata (key_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    key_ready = 1'b0;
    din_ready = 1'b0;
    busy      = (state == LOAD) || (state == RUN);
`ifdef OPT_KEY_WRAP_EN
    exhausted = wrap_p1;
`else
    exhausted = (state == EXHAUSTED);
`endif
    // clear blocks every handshake in its own cycle
    if (ena && !clear) begin
      key_ready = (state == LOAD);
      din_ready = (state == RUN) && (!vld_p1 || dout_ready);
    end
    key_acc  = key_ready && key_valid;
    din_acc  = din_ready && din_valid;
    last_key = key_acc && (key_last || (cnt == CNT_LAST));
    last_rd  = din_acc && (rd_inc == cnt);
    load_go  = ena && !clear && cmd_load && ((state == IDLE) || (state == EXHAUSTED));

    if (clear) begin
      state_nxt = IDLE;
    end else if (ena) begin
      case (state)
        IDLE:      if (cmd_load) state_nxt = LOAD;
        LOAD:      if (last_key) state_nxt = RUN;
`ifdef OPT_KEY_WRAP_EN
        RUN:       state_nxt = RUN;
`else
        RUN:       if (last_rd)  state_nxt = EXHAUSTED;
`endif
        EXHAUSTED: if (cmd_load) state_nxt = LOAD;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // Stage p1: pointers, result register and valid
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr  <= '0;
      cnt     <= '0;
      rd_idx  <= '0;
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
`ifdef OPT_KEY_WRAP_EN
      wrap_p1 <= 1'b0;
`endif
    end else if (ena) begin
`ifdef OPT_KEY_WRAP_EN
      wrap_p1 <= 1'b0;
`endif
      if (load_go) begin
        wr_ptr <= '0;
        cnt    <= '0;
        rd_idx <= '0;
      end
      if (key_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
        cnt    <= cnt + 1'b1;
      end
      if (din_acc) begin
        dout_p1 <= din ^ key_rd;
        vld_p1  <= 1'b1;
`ifdef OPT_KEY_WRAP_EN
        if (last_rd) begin
          rd_idx  <= '0;
          wrap_p1 <= 1'b1;
        end else begin
          rd_idx  <= rd_inc;
        end
`else
        rd_idx  <= rd_inc;
`endif
      end else if (dout_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign dout       = dout_p1;
  assign dout_valid = vld_p1;
  assign key_count  = cnt;

endmodule

// File: tb/tb_opt_key_sequencer.sv
// Self-checking bench for opt_key_sequencer with a queue-based one-time-pad reference model.
module tb_opt_key_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, ena = 1'b1, cmd_load = 1'b0, clear = 1'b0;
  logic       key_valid = 1'b0, key_last = 1'b0, din_valid = 1'b0, dout_ready = 1'b0;
  logic [7:0] key_byte = '0, din = '0;
  logic       key_ready, din_ready, dout_valid, busy, exhausted;
  logic [7:0] dout;
  logic [4:0] key_count;

  int n_chk = 0, n_fail = 0, cyc = 0, k = 0, exh_cnt = 0;
  logic [7:0] kq[$];
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_cyc[$];
  logic       lat_pend = 1'b0, hold_pend = 1'b0;
  logic [7:0] hold_val = '0;
  bit         rand_rdy = 0, rand_ena = 0;

  opt_key_sequencer #(.KEY_DEPTH(16), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cmd_load(cmd_load), .clear(clear),
    .key_valid(key_valid), .key_byte(key_byte), .key_last(key_last), .key_ready(key_ready),
    .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .dout_valid(dout_valid), .dout(dout), .dout_ready(dout_ready),
    .busy(busy), .exhausted(exhausted), .key_count(key_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: every accepted data byte consumes the next key byte in load order.
  always @(negedge clk) begin
    cyc++;
    if (exhausted) exh_cnt++;
    if (!rst_n || clear) begin
      exp_q.delete();
      lat_pend  = 1'b0;
      hold_pend = 1'b0;
    end else begin
      if (lat_pend) chk("latency", dout_valid, 1);
      lat_pend = 1'b0;
      if (hold_pend && dout_valid) chk("dout_hold", dout, hold_val);
      if (ena && dout_valid && dout_ready) begin
        obs_q.push_back(dout);
        obs_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("dout_spurious", 1, 0);
        else chk("dout", dout, exp_q.pop_front());
      end
      if (ena && din_valid && din_ready) begin
`ifndef OPT_KEY_WRAP_EN
        if (k >= kq.size()) chk("key_reuse", k, kq.size());
`endif
        if (kq.size() == 0) chk("din_no_key", 1, 0);
        else exp_q.push_back(din ^ kq[k % kq.size()]);
        k++;
        lat_pend = 1'b1;
      end
      if (ena && key_valid && key_ready) kq.push_back(key_byte);
      hold_pend = dout_valid && !(ena && dout_ready);
      hold_val  = dout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) dout_ready = 1'($urandom_range(0, 1));
    if (rand_ena) ena = ($urandom_range(0, 4) != 0);
  endtask

  task automatic start_load();
`ifdef OPT_KEY_WRAP_EN
    clear = 1'b1;
    tick();
    clear = 1'b0;
`endif
    kq.delete();
    k = 0;
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
  endtask

  task automatic send_key(input logic [7:0] b, input logic last);
    int n = 0;
    key_valid = 1'b1; key_byte = b; key_last = last;
    @(negedge clk);
    while (!key_ready && n < 50) begin tick(); @(negedge clk); n++; end
    if (n >= 50) chk("key_timeout", 0, 1);
    tick();
    key_valid = 1'b0; key_last = 1'b0;
  endtask

  task automatic send_din(input logic [7:0] b);
    int n = 0;
    din_valid = 1'b1; din = b;
    @(negedge clk);
    while (!din_ready && n < 50) begin tick(); @(negedge clk); n++; end
    if (n >= 50) chk("din_timeout", 0, 1);
    tick();
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rand_rdy = 0; rand_ena = 0; ena = 1'b1; dout_ready = 1'b1;
    @(negedge clk);
    while (dout_valid && n < 20) begin tick(); @(negedge clk); n++; end
    if (n >= 20) chk("drain_timeout", 0, 1);
    tick();
  endtask

  initial begin
    logic [7:0] r;
    int len;
    bit use_last;

    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_exhausted", exhausted, 0);
    chk("rst_key_ready", key_ready, 0);
    chk("rst_din_ready", din_ready, 0);
    chk("rst_key_count", key_count, 0);
    tick();

    // Basic key 11,22,33 and three back-to-back data bytes
    dout_ready = 1'b1;
    start_load();
    send_key(8'h11, 0); send_key(8'h22, 0); send_key(8'h33, 1);
    @(negedge clk);
    chk("run_din_ready", din_ready, 1);
    chk("run_key_count", key_count, 3);
    chk("run_key_ready", key_ready, 0);
    tick();
    obs_q.delete(); obs_cyc.delete();
    send_din(8'hA0); send_din(8'hB0); send_din(8'hC0);
    @(negedge clk);
`ifndef OPT_KEY_WRAP_EN
    chk("exh_flag", exhausted, 1);
    chk("exh_din_ready", din_ready, 0);
    chk("exh_busy", busy, 0);
`endif
    tick();
    chk("basic_count", obs_q.size(), 3);
    if (obs_q.size() >= 3) begin
      chk("basic_b1", obs_q[0], 8'hB1);
      chk("basic_92", obs_q[1], 8'h92);
      chk("basic_f3", obs_q[2], 8'hF3);
      chk("basic_back2back", obs_cyc[2] - obs_cyc[0], 2);
    end
    drain();

    // Full-depth key without key_last, then a refused 17th byte
    start_load();
    for (int i = 0; i < 16; i++) send_key(8'($urandom), 0);
    key_valid = 1'b1; key_byte = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      chk("full_key_ready", key_ready, 0);
      chk("full_key_count", key_count, 16);
      tick();
    end
    key_valid = 1'b0;
    rand_rdy = 1;
    for (int i = 0; i < 16; i++) send_din(8'($urandom));
    drain();
`ifndef OPT_KEY_WRAP_EN
    @(negedge clk);
    chk("full_exhausted", exhausted, 1);
    tick();
`endif

    // Back-pressure: result held while downstream stalls
    dout_ready = 1'b1;
    start_load();
    send_key(8'h11, 0); send_key(8'h22, 0); send_key(8'h33, 1);
    dout_ready = 1'b0;
    send_din(8'hA0);
    din_valid = 1'b1; din = 8'hB0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_din_ready", din_ready, 0);
      chk("bp_dout", dout, 8'hB1);
      tick();
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    send_din(8'hB0); send_din(8'hC0);
    drain();

    // clear in RUN after one byte, then a zero key passes data through
    start_load();
    for (int i = 0; i < 4; i++) send_key(8'($urandom), i == 3);
    send_din(8'($urandom));
    clear = 1'b1; din_valid = 1'b1; din = 8'h77;
    @(negedge clk);
    chk("clr_din_ready", din_ready, 0);
    tick();
    clear = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    chk("clr_busy", busy, 0);
    chk("clr_key_count", key_count, 0);
    chk("clr_dout_valid", dout_valid, 0);
    chk("clr_key_ready", key_ready, 0);
    tick();
    start_load();
    send_key(8'h00, 1);
    r = 8'($urandom);
    send_din(r);
    @(negedge clk);
    chk("clr_passthru", dout, r);
    tick();
    drain();

    // ena dropped mid-load
    start_load();
    send_key(8'h3C, 0); send_key(8'hC3, 0);
    ena = 1'b0; key_valid = 1'b1; key_byte = 8'h99;
    repeat (2) begin
      @(negedge clk);
      chk("ena_key_ready", key_ready, 0);
      chk("ena_key_count", key_count, 2);
      tick();
    end
    ena = 1'b1;
    send_key(8'h99, 0); send_key(8'h66, 1);
    @(negedge clk);
    chk("ena_load_done", key_count, 4);
    tick();
    for (int i = 0; i < 4; i++) send_din(8'($urandom));
    drain();

    // Randomized keys and streams with random back-pressure and ena
    repeat (6) begin
      len = $urandom_range(1, 16);
      use_last = (len < 16) ? 1 : bit'($urandom_range(0, 1));
      start_load();
      for (int i = 0; i < len; i++) send_key(8'($urandom), use_last && (i == len - 1));
      @(negedge clk);
      chk("rand_key_count", key_count, len);
      tick();
      rand_rdy = 1; rand_ena = 1;
`ifdef OPT_KEY_WRAP_EN
      for (int i = 0; i < 2 * len; i++) send_din(8'($urandom));
`else
      for (int i = 0; i < len; i++) send_din(8'($urandom));
`endif
      drain();
`ifndef OPT_KEY_WRAP_EN
      din_valid = 1'b1; din = 8'h00;
      @(negedge clk);
      chk("rand_exhausted", exhausted, 1);
      chk("rand_din_ready", din_ready, 0);
      tick();
      din_valid = 1'b0;
`endif
    end

`ifdef OPT_KEY_WRAP_EN
    // Repeating-key mode: two-byte key, four zero bytes
    dout_ready = 1'b1;
    start_load();
    send_key(8'h0F, 0); send_key(8'hF0, 1);
    obs_q.delete();
    exh_cnt = 0;
    repeat (4) send_din(8'h00);
    drain();
    chk("wrap_pulses", exh_cnt, 2);
    chk("wrap_count", obs_q.size(), 4);
    if (obs_q.size() >= 4) begin
      chk("wrap_0", obs_q[0], 8'h0F);
      chk("wrap_1", obs_q[1], 8'hF0);
      chk("wrap_2", obs_q[2], 8'h0F);
      chk("wrap_3", obs_q[3], 8'hF0);
    end
`endif

    // Reset mid-operation discards key and pending result
    start_load();
    send_key(8'hAB, 1);
    dout_ready = 1'b0;
    send_din(8'h12);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_dout_valid", dout_valid, 0);
    chk("mrst_key_count", key_count, 0);
    chk("mrst_busy", busy, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
